// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bus of instr_prefetch_queue: instruction-memory handshake plus CPU delivery port.
// The prefetch queue uses the master modport; memory/CPU models use the slave modport.
interface instr_prefetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with one outstanding memory request and a DEPTH-entry FIFO.
// Define IFQ_PERF_EN to add the perf_bubble_cnt / perf_drop_cnt counters.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n,
    instr_prefetch_queue_if.master bus
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [15:0] perf_drop_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    entry_t        head_q, head_d;
    entry_t        fifo_q [DEPTH];
    entry_t        push_entry;
    logic          grant, push, pop;
`ifdef IFQ_PERF_EN
    logic          drop_rsp;
    logic [31:0]   bubble_q, bubble_d;
    logic [15:0]   drop_q, drop_d;
`endif

    // A redirect withdraws an unanswered request in the same cycle.
    assign bus.mem_req     = req_q && !bus.redirect;
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = head_q.word;
    assign bus.instr_pc    = head_q.pc;

    assign grant      = bus.mem_req && bus.mem_gnt;
    assign push       = (state_q == WAIT) && bus.mem_rvalid && !bus.redirect;
    assign pop        = valid_q && bus.instr_ready && !bus.redirect;
    assign push_entry = '{pc: fetch_pc_q - 32'd4, word: bus.mem_rdata};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d    = WAIT;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            WAIT: begin
                if (bus.mem_rvalid)    state_d = IDLE;
                else if (bus.redirect) state_d = DROP;
            end
            DROP: if (bus.mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.redirect) fetch_pc_d = bus.redirect_pc & ~32'h3;

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (bus.redirect) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end

        // Head register preloads next cycle's FIFO head; it may be the word being pushed now.
        valid_d = (count_d != '0);
        head_d  = head_q;
        if (valid_d) head_d = (push && rd_ptr_d == wr_ptr_q) ? push_entry : fifo_q[rd_ptr_d];

        req_d = (state_d == IDLE) && (count_d < DEPTH_C);

`ifdef IFQ_PERF_EN
        drop_rsp = bus.mem_rvalid && ((state_q == DROP) || (state_q == WAIT && bus.redirect));
        bubble_d = bubble_q;
        drop_d   = drop_q;
        if (bus.instr_ready && !valid_q && bubble_q != '1) bubble_d = bubble_q + 32'd1;
        if (drop_rsp && drop_q != '1)                      drop_d   = drop_q + 16'd1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
`ifdef IFQ_PERF_EN
            bubble_q   <= '0;
            drop_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
`ifdef IFQ_PERF_EN
            bubble_q   <= bubble_d;
            drop_q     <= drop_d;
`endif
        end
    end

    // NOTE: FIFO storage has no reset; count/valid gate every read, so stale slots are never seen.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

`ifdef IFQ_PERF_EN
    assign perf_bubble_cnt = bubble_q;
    assign perf_drop_cnt   = drop_q;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed scenarios plus randomized traffic for instr_prefetch_queue against a PC-stream model.
// Define IFQ_PERF_EN to also check the performance counters.
module tb_instr_prefetch_queue;
    logic clk;
    logic rst_n;
    instr_prefetch_queue_if bus();
`ifdef IFQ_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [15:0] perf_drop_cnt;
`endif

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IFQ_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_drop_cnt   (perf_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Knobs
    int gnt_pct, rdy_pct, lat_lo, lat_hi;

    // Reference model: the delivered stream is sequential from the last redirect target.
    logic [31:0] exp_pc, model_addr, hold_pc, hold_word, pend_addr, first_pc_after_redir;
    logic [31:0] bubble_m, drop_m;
    bit          pending, pend_stale, prev_redir, await_redir, last_req, last_vld;
    int          lat, gnts, rsps, pops, cyc_n, first_gnt_cyc, first_valid_cyc;
    logic [31:0] gnt_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F96 ^ {pc[15:0], pc[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        #1;
        check("rst_mem_req",     bus.mem_req,     0);
        check("rst_mem_addr",    bus.mem_addr,    32'h0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr",       bus.instr,       32'h0);
        check("rst_instr_pc",    bus.instr_pc,    32'h0);
`ifdef IFQ_PERF_EN
        check("rst_perf_bubble", perf_bubble_cnt, 32'h0);
        check("rst_perf_drop",   perf_drop_cnt,   32'h0);
`endif
        exp_pc = '0; model_addr = '0; hold_pc = '0; hold_word = '0;
        bubble_m = '0; drop_m = '0;
        pending = 0; pend_stale = 0; prev_redir = 0; await_redir = 0;
        lat = 0; gnts = 0; rsps = 0; pops = 0; cyc_n = 0;
        first_gnt_cyc = -1; first_valid_cyc = -1; first_pc_after_redir = 32'hDEAD_BEEF;
        gnt_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs after negedge, check outputs, then advance the model.
    task automatic cyc(input bit redir, input logic [31:0] tgt);
        bit g, rv, rdy, req, vld, pop;
        @(negedge clk);
        rv  = pending && (lat == 0);
        g   = ($urandom_range(1, 100) <= gnt_pct);
        rdy = ($urandom_range(1, 100) <= rdy_pct);
        bus.mem_gnt     = g;
        bus.mem_rvalid  = rv;
        bus.mem_rdata   = rv ? word_of(pend_addr) : $urandom;
        bus.redirect    = redir;
        bus.redirect_pc = tgt;
        bus.instr_ready = rdy;
        #1;
        req = bus.mem_req;
        vld = bus.instr_valid;
        if (pending)    check("req_while_outstanding", req, 0);
        if (redir)      check("req_on_redirect", req, 0);
        if (req)        check("mem_addr", bus.mem_addr, model_addr);
        if (prev_redir) check("valid_after_redirect", vld, 0);
        if (vld) begin
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr", bus.instr, word_of(exp_pc));
            hold_pc   = exp_pc;
            hold_word = word_of(exp_pc);
            if (first_valid_cyc < 0) first_valid_cyc = cyc_n;
            if (await_redir && !redir) begin
                first_pc_after_redir = bus.instr_pc;
                await_redir = 0;
            end
        end else begin
            check("hold_instr_pc", bus.instr_pc, hold_pc);
            check("hold_instr", bus.instr, hold_word);
        end
`ifdef IFQ_PERF_EN
        check("perf_bubble", perf_bubble_cnt, bubble_m);
        check("perf_drop", {16'h0, perf_drop_cnt}, drop_m);
        if (rdy && !vld) bubble_m = bubble_m + 1;
`endif
        pop = vld && rdy && !redir;
        if (pop) begin
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (rv) begin
            if (pend_stale || redir) drop_m = drop_m + 1;
            pending = 0;
            rsps++;
        end else if (pending) begin
            lat--;
        end
        if (req && g) begin
            pending    = 1;
            pend_stale = 0;
            pend_addr  = bus.mem_addr;
            lat        = $urandom_range(lat_lo, lat_hi);
            model_addr = model_addr + 32'd4;
            gnt_q.push_back(bus.mem_addr);
            gnts++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc_n;
        end
        if (redir) begin
            exp_pc      = tgt & ~32'h3;
            model_addr  = tgt & ~32'h3;
            await_redir = 1;
            if (pending) pend_stale = 1;
        end
        prev_redir = redir;
        last_req   = req;
        last_vld   = vld;
        cyc_n++;
    endtask

    initial begin
        logic [31:0] tgt, a;
        rst_n = 1'b1;

        // 1: back-to-back fetch, one-cycle memory, CPU always ready
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 12; i++) cyc(0, '0);
        check("s1_first_latency", first_valid_cyc - first_gnt_cyc, 2);
        check("s1_delivered", pops >= 4, 1);

        // 2: CPU stalled fills exactly DEPTH entries, then drains and resumes at 0x10
        do_reset();
        gnt_pct = 100; rdy_pct = 0;
        for (int i = 0; i < 20; i++) cyc(0, '0);
        check("s2_fill_grants", gnts, 4);
        check("s2_full_no_req", last_req, 0);
        check("s2_full_valid", last_vld, 1);
        rdy_pct = 100;
        for (int i = 0; i < 12; i++) cyc(0, '0);
        check("s2_pops", pops >= 4, 1);
        a = (gnt_q.size() > 4) ? gnt_q[4] : 32'hDEAD_BEEF;
        check("s2_resume_addr", a, 32'h10);

        // 3: grant withheld, request held with fixed address, one grant only
        do_reset();
        gnt_pct = 0; rdy_pct = 100;
        for (int i = 0; i < 6; i++) begin
            cyc(0, '0);
            if (i >= 1) check("s3_req_held", last_req, 1);
        end
        check("s3_no_grant", gnts, 0);
        gnt_pct = 100; lat_lo = 3; lat_hi = 3;
        cyc(0, '0);
        check("s3_one_grant", gnts, 1);
        cyc(0, '0);
        check("s3_wait_no_req", last_req, 0);

        // 4: redirect while waiting, stale response 3 cycles later
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 10 && gnts < 1; i++) cyc(0, '0);
        check("s4_grant_seen", gnts, 1);
        cyc(1, 32'h0000_1003);
        lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 20; i++) cyc(0, '0);
        a = (gnt_q.size() > 1) ? gnt_q[1] : 32'hDEAD_BEEF;
        check("s4_redir_addr", a, 32'h1000);
        check("s4_first_pc", first_pc_after_redir, 32'h1000);
`ifdef IFQ_PERF_EN
        check("s4_perf_drop", {16'h0, perf_drop_cnt}, 32'd1);
`endif

        // 5: redirect with 3 buffered entries and a coincident pop
        do_reset();
        gnt_pct = 100; rdy_pct = 0; lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 20 && rsps < 3; i++) cyc(0, '0);
        check("s5_three_buffered", rsps, 3);
        rdy_pct = 100;
        cyc(1, 32'h0000_2000);
        cyc(0, '0);
        check("s5_flushed", last_vld, 0);
        for (int i = 0; i < 15; i++) cyc(0, '0);
        check("s5_first_pc", first_pc_after_redir, 32'h2000);

        // Address wrap at the top of memory
        cyc(1, 32'hFFFF_FFF9);
        for (int i = 0; i < 20; i++) cyc(0, '0);
        check("wrap_first_pc", first_pc_after_redir, 32'hFFFF_FFF8);

        // Randomized traffic with occasional redirects, then mid-run reset
        do_reset();
        gnt_pct = 70; rdy_pct = 70; lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            cyc($urandom_range(0, 29) == 0, tgt);
        end
        gnt_pct = 100; rdy_pct = 100;
        for (int i = 0; i < 30; i++) cyc(0, '0);
        check("rand_progress", pops > 100, 1);
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
